// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the clock period monitor.
package clk_mon_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEASURE
   } mon_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus an edge flop; emits a one-cycle pulse on each
// synchronized rising edge of an asynchronous input.
module sync_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_async,
   output logic sig_sync,
   output logic rise
);

   // [0]/[1] are the metastability pair, [2] holds the previous synced value
   logic [2:0] sync_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_pipe <= '0;
      else        sync_pipe <= {sync_pipe[1:0], sig_async};
   end

   assign sig_sync = sync_pipe[1];
   assign rise     = sync_pipe[1] & ~sync_pipe[2];

endmodule

// File: rtl/clk_period_monitor.sv
// Measures period and high time of an asynchronous signal in clk cycles and
// presents each result on a valid/ready port, with stuck/glitch/overrun flags.
module clk_period_monitor
   import clk_mon_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int MIN_PERIOD = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             sig_in,
   output logic [CNT_W-1:0] meas_period,
   output logic [CNT_W-1:0] meas_high,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic             overrun,
   output logic             stuck,
   output logic             glitch
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);

   mon_state_e       state, next_state;
   logic [CNT_W-1:0] per_cnt, hi_cnt;
   logic             sig_sync, rise;
   logic             start, capture, sat, clr;

   sync_edge_detect u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .sig_async (sig_in),
      .sig_sync  (sig_sync),
      .rise      (rise)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      start      = 1'b0;
      capture    = 1'b0;
      sat        = 1'b0;
      if (!enable) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: next_state = ARM;
            ARM: if (rise) begin
               start      = 1'b1;
               next_state = MEASURE;
            end
            MEASURE: begin
               // a saturated period is meaningless, so it wins over a rise
               if (per_cnt == CNT_MAX) begin
                  sat        = 1'b1;
                  next_state = ARM;
               end else if (rise) begin
                  capture = 1'b1;
                  start   = 1'b1;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   assign clr = !enable || (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end else if (clr) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end else if (start) begin
         per_cnt <= CNT_ONE;
         hi_cnt  <= sig_sync ? CNT_ONE : '0;
      end else if (state == MEASURE && !sat) begin
         per_cnt <= per_cnt + CNT_ONE;
         if (sig_sync && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meas_period <= '0;
         meas_high   <= '0;
         meas_valid  <= 1'b0;
         overrun     <= 1'b0;
         stuck       <= 1'b0;
         glitch      <= 1'b0;
      end else if (clr) begin
         meas_period <= '0;
         meas_high   <= '0;
         meas_valid  <= 1'b0;
         overrun     <= 1'b0;
         stuck       <= 1'b0;
         glitch      <= 1'b0;
      end else begin
         if (sat)       stuck <= 1'b1;
         else if (rise) stuck <= 1'b0;

         if (capture && per_cnt < MIN_P) begin
            glitch <= 1'b1;
         end else if (capture) begin
            // the held result stays put until the consumer takes it
            if (!meas_valid || meas_ready) begin
               meas_period <= per_cnt;
               meas_high   <= hi_cnt;
               meas_valid  <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Scoreboard bench for clk_period_monitor: stimulus pushes expected results,
// a negedge monitor pops them on each handshake.
module tb_clk_period_monitor;
   import clk_mon_pkg::*;

   localparam int CW = CNT_W_DEF;

   logic          clk = 1'b0, rst_n = 1'b1, enable = 1'b0, sig_in = 1'b0, meas_ready = 1'b0;
   logic [CW-1:0] meas_period, meas_high;
   logic          meas_valid, overrun, stuck, glitch;

   logic          enable4 = 1'b0, sig4 = 1'b0, ready4 = 1'b0;
   logic [3:0]    period4, high4;
   logic          valid4, overrun4, stuck4, glitch4;

   typedef struct packed {
      logic [CW-1:0] per;
      logic [CW-1:0] hi;
   } res_t;

   res_t sb_q[$];
   res_t exp_r;
   int   n_cmp = 0, n_err = 0;
   int   gen_per = 0, gen_hi = 0;
   bit   gen_armed = 0, push_en = 1, seen_valid4 = 0;

   always #5 clk = ~clk;

   clk_period_monitor u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
      .meas_period(meas_period), .meas_high(meas_high), .meas_valid(meas_valid),
      .meas_ready(meas_ready), .overrun(overrun), .stuck(stuck), .glitch(glitch)
   );

   clk_period_monitor #(.CNT_W(4), .MIN_PERIOD(3)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .enable(enable4), .sig_in(sig4),
      .meas_period(period4), .meas_high(high4), .meas_valid(valid4),
      .meas_ready(ready4), .overrun(overrun4), .stuck(stuck4), .glitch(glitch4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && meas_valid && meas_ready) begin
         if (sb_q.size() == 0) chk("unexpected_result", {31'd0, meas_valid}, 32'd0);
         else begin
            exp_r = sb_q.pop_front();
            chk("period", 32'(meas_period), 32'(exp_r.per));
            chk("high", 32'(meas_high), 32'(exp_r.hi));
         end
      end
      if (valid4) seen_valid4 = 1;
   end

   // one clk cycle per step; expected values come from counting what we drive
   task automatic drive(input logic lvl, input int n);
      res_t r;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (lvl && !sig_in) begin
            if (gen_armed && push_en) begin
               r.per = CW'(gen_per);
               r.hi  = CW'(gen_hi);
               sb_q.push_back(r);
            end
            gen_armed = 1;
            gen_per   = 0;
            gen_hi    = 0;
         end
         sig_in = lvl;
         gen_per++;
         if (lvl) gen_hi++;
      end
   endtask

   task automatic run(input int hi_n, input int lo_n, input int reps);
      for (int i = 0; i < reps; i++) begin
         drive(1'b1, hi_n);
         drive(1'b0, lo_n);
      end
   endtask

   task automatic restart();
      @(posedge clk); #1 enable = 1'b0;
      @(posedge clk); #1 enable = 1'b1;
      gen_armed = 0;
      drive(1'b0, 2);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      #2 rst_n = 1'b0;
      #10;
      chk("rst_valid", {31'd0, meas_valid}, 0);
      chk("rst_period", 32'(meas_period), 0);
      chk("rst_high", 32'(meas_high), 0);
      chk("rst_overrun", {31'd0, overrun}, 0);
      chk("rst_stuck", {31'd0, stuck}, 0);
      chk("rst_glitch", {31'd0, glitch}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      enable = 1'b1; enable4 = 1'b1; meas_ready = 1'b1; ready4 = 1'b1;

      // square wave, 5 high / 5 low
      drive(1'b0, 3);
      run(5, 5, 5);
      drive(1'b0, 8);
      chk("t1_drain", sb_q.size(), 0);
      chk("t1_overrun", {31'd0, overrun}, 0);
      chk("t1_stuck", {31'd0, stuck}, 0);
      chk("t1_glitch", {31'd0, glitch}, 0);

      // 3 high / 7 low
      restart();
      run(3, 7, 5);
      drive(1'b0, 8);
      chk("t2_drain", sb_q.size(), 0);
      chk("t2_overrun", {31'd0, overrun}, 0);

      // back-pressure: first result held, later ones dropped
      restart();
      meas_ready = 1'b0;
      run(5, 5, 1);
      drive(1'b1, 5); drive(1'b0, 5);
      chk("t3_valid", {31'd0, meas_valid}, 1);
      chk("t3_overrun_pre", {31'd0, overrun}, 0);
      push_en = 0;
      drive(1'b1, 5);
      chk("t3_overrun", {31'd0, overrun}, 1);
      chk("t3_hold_period", 32'(meas_period), 10);
      chk("t3_hold_high", 32'(meas_high), 5);
      drive(1'b0, 5); drive(1'b1, 5); drive(1'b0, 1);
      chk("t3_hold_period2", 32'(meas_period), 10);
      chk("t3_valid2", {31'd0, meas_valid}, 1);
      meas_ready = 1'b1;
      push_en = 1;
      drive(1'b0, 4);
      run(5, 5, 3);
      drive(1'b0, 8);
      chk("t3_drain", sb_q.size(), 0);
      chk("t3_overrun_sticky", {31'd0, overrun}, 1);

      // enable drop with a pending result and overrun set
      restart();
      chk("t5_overrun_clr", {31'd0, overrun}, 0);
      meas_ready = 1'b0;
      run(5, 5, 1);
      drive(1'b1, 5); drive(1'b0, 5);
      push_en = 0;
      drive(1'b1, 5); drive(1'b0, 2);
      chk("t5_valid_pre", {31'd0, meas_valid}, 1);
      chk("t5_overrun_pre", {31'd0, overrun}, 1);
      enable = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("t5_valid_drop", {31'd0, meas_valid}, 0);
      chk("t5_overrun_drop", {31'd0, overrun}, 0);
      chk("t5_stuck_drop", {31'd0, stuck}, 0);
      chk("t5_glitch_drop", {31'd0, glitch}, 0);
      sb_q.delete();
      gen_armed = 0; push_en = 1; meas_ready = 1'b1;
      @(posedge clk); #1 enable = 1'b1;
      drive(1'b0, 3);
      run(5, 5, 3);
      drive(1'b0, 8);
      chk("t5_drain", sb_q.size(), 0);

      // async reset between edges with a pending result
      meas_ready = 1'b0;
      run(5, 5, 1);
      drive(1'b1, 5); drive(1'b0, 5);
      chk("t6_valid_pre", {31'd0, meas_valid}, 1);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      chk("t6_valid_rst", {31'd0, meas_valid}, 0);
      chk("t6_period_rst", 32'(meas_period), 0);
      chk("t6_high_rst", 32'(meas_high), 0);
      sb_q.delete();
      gen_armed = 0; meas_ready = 1'b1;
      @(posedge clk); #4 rst_n = 1'b1;
      drive(1'b0, 3);
      run(5, 5, 3);
      drive(1'b0, 8);
      chk("t6_drain", sb_q.size(), 0);

      // CNT_W=4: stuck after one rise then constant low
      seen_valid4 = 0;
      @(posedge clk); #1 sig4 = 1'b1;
      repeat (3) @(posedge clk);
      #1 sig4 = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      chk("t4_stuck_early", {31'd0, stuck4}, 0);
      @(posedge clk); @(negedge clk);
      chk("t4_stuck_set", {31'd0, stuck4}, 1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("t4_stuck_hold", {31'd0, stuck4}, 1);
      @(posedge clk); #1 sig4 = 1'b1;
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("t4_stuck_before_rise", {31'd0, stuck4}, 1);
      @(posedge clk); @(negedge clk);
      chk("t4_stuck_clear", {31'd0, stuck4}, 0);
      chk("t4_no_result", {31'd0, seen_valid4}, 0);
      #1 sig4 = 1'b0;

      // MIN_PERIOD=3: period 2 is a glitch, period 3 is accepted
      @(posedge clk); #1 enable4 = 1'b0;
      @(posedge clk); #1 enable4 = 1'b1;
      @(posedge clk); #1 seen_valid4 = 0;
      chk("t7_glitch_clr", {31'd0, glitch4}, 0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1 sig4 = ~sig4;
      end
      sig4 = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("t7_glitch_set", {31'd0, glitch4}, 1);
      chk("t7_glitch_no_result", {31'd0, seen_valid4}, 0);
      @(posedge clk); #1 enable4 = 1'b0; ready4 = 1'b0;
      @(posedge clk); #1 enable4 = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1 sig4 = 1'b1;
         @(posedge clk); #1 sig4 = 1'b0;
         @(posedge clk);
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("t8_valid", {31'd0, valid4}, 1);
      chk("t8_period", 32'(period4), 3);
      chk("t8_high", 32'(high4), 1);
      chk("t8_glitch", {31'd0, glitch4}, 0);
      chk("t8_overrun", {31'd0, overrun4}, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
